// File: rtl/tone_mix_gen.sv
// tone_mix_gen: NCH-tone phase sweep for external CORDICs, plus a decimated mix of their sin/cos results.
// Optional build macro TONE_MIX_SAT_EN: saturating unity-gain sum instead of averaging.
`default_nettype none

module tone_mix_gen #(
  parameter int NCH    = 2,
  parameter int W      = 16,
  parameter int DECIM  = 5,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NCH*W-1:0]     phase_inc,
  output logic                 phase_tvalid,
  output logic [NCH*W-1:0]     phase_tdata,
  input  logic [NCH-1:0]       sincos_tvalid,
  input  logic [NCH*2*W-1:0]   sincos_tdata,
  output logic                 mix_tvalid,
  output logic [W-1:0]         mix_sin,
  output logic [W-1:0]         mix_cos,
  output logic                 running
);

  localparam int LG  = (NCH > 1) ? $clog2(NCH) : 0;
  localparam int SW  = W + LG;
  localparam int PW  = W + 2;
  localparam int DW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // +/-pi and 2pi in 1.2.13, held in W+2 bits so phase+inc cannot overflow
  localparam logic signed [PW-1:0] PI_POS = PW'(25736);
  localparam logic signed [PW-1:0] PI_NEG = PW'(-25736);
  localparam logic signed [PW-1:0] TWO_PI = PW'(51472);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_q;
  logic [NCH*W-1:0]   phase_q;
  logic [NCH*W-1:0]   phase_d;
  logic [DW-1:0]      dec_q;
  logic [STW-1:0]     settle_q;
  logic               all_valid;

  logic signed [PW-1:0] ph_cur, ph_inc, ph_sum, ph_next;
  logic signed [SW-1:0] ext_sin, ext_cos, sum_sin, sum_cos;
  logic signed [SW-1:0] shf_sin, shf_cos;
  logic [W-1:0]         comb_sin, comb_cos;

  assign all_valid   = &sincos_tvalid;
  assign phase_tdata = phase_q;

  always_comb begin
    phase_d = phase_q;
    ph_cur  = '0;
    ph_inc  = '0;
    ph_sum  = '0;
    ph_next = '0;
    for (int k = 0; k < NCH; k++) begin
      ph_cur = $signed(phase_q[k*W +: W]);
      ph_inc = $signed(phase_inc[k*W +: W]);
      ph_sum = ph_cur + ph_inc;
      if (ph_sum >= PI_POS) begin
        ph_next = ph_sum - TWO_PI;
      end else if (ph_sum < PI_NEG) begin
        ph_next = ph_sum + TWO_PI;
      end else begin
        ph_next = ph_sum;
      end
      phase_d[k*W +: W] = ph_next[W-1:0];
    end
  end

  // Exact sum over all tones; the widened accumulator makes overflow impossible
  always_comb begin
    sum_sin = '0;
    sum_cos = '0;
    ext_sin = '0;
    ext_cos = '0;
    for (int k = 0; k < NCH; k++) begin
      ext_sin = $signed(sincos_tdata[k*2*W + W +: W]);
      ext_cos = $signed(sincos_tdata[k*2*W +: W]);
      sum_sin = sum_sin + ext_sin;
      sum_cos = sum_cos + ext_cos;
    end
  end

`ifdef TONE_MIX_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2**(W-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2**(W-1)));

  always_comb begin
    shf_sin = sum_sin;
    shf_cos = sum_cos;
    if (sum_sin > SAT_MAX) begin
      shf_sin = SAT_MAX;
    end else if (sum_sin < SAT_MIN) begin
      shf_sin = SAT_MIN;
    end
    if (sum_cos > SAT_MAX) begin
      shf_cos = SAT_MAX;
    end else if (sum_cos < SAT_MIN) begin
      shf_cos = SAT_MIN;
    end
    comb_sin = shf_sin[W-1:0];
    comb_cos = shf_cos[W-1:0];
  end
`else
  always_comb begin
    shf_sin  = sum_sin >>> LG;
    shf_cos  = sum_cos >>> LG;
    comb_sin = shf_sin[W-1:0];
    comb_cos = shf_cos[W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      dec_q        <= '0;
      settle_q     <= '0;
      phase_tvalid <= 1'b0;
      mix_tvalid   <= 1'b0;
      mix_sin      <= '0;
      mix_cos      <= '0;
      running      <= 1'b0;
    end else begin
      mix_tvalid <= 1'b0;
      if (!enable) begin
        // Dropping enable discards any sample that would have been due this edge
        state_q      <= ST_IDLE;
        phase_q      <= '0;
        dec_q        <= '0;
        settle_q     <= '0;
        phase_tvalid <= 1'b0;
        running      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q      <= ST_PRIME;
            phase_q      <= '0;
            dec_q        <= '0;
            settle_q     <= '0;
            phase_tvalid <= 1'b1;
          end
          ST_PRIME: begin
            phase_q <= phase_d;
            if (SETTLE == 0) begin
              state_q <= ST_RUN;
              running <= 1'b1;
            end else if (all_valid) begin
              if (settle_q == STW'(SETTLE - 1)) begin
                state_q  <= ST_RUN;
                running  <= 1'b1;
                settle_q <= '0;
              end else begin
                settle_q <= settle_q + STW'(1);
              end
            end
          end
          ST_RUN: begin
            phase_q <= phase_d;
            if (all_valid) begin
              if (dec_q == DW'(DECIM - 1)) begin
                dec_q      <= '0;
                mix_sin    <= comb_sin;
                mix_cos    <= comb_cos;
                mix_tvalid <= 1'b1;
              end else begin
                dec_q <= dec_q + DW'(1);
              end
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            phase_tvalid <= 1'b0;
            running      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tone_mix_gen.sv
// Directed self-checking bench for tone_mix_gen (NCH=2, W=16, DECIM=5, SETTLE=4).
`default_nettype none

module tb_tone_mix_gen;

  localparam int NCH = 2;
  localparam int W   = 16;

  logic                 clk;
  logic                 reset_n;
  logic                 enable;
  logic [NCH*W-1:0]     phase_inc;
  logic                 phase_tvalid;
  logic [NCH*W-1:0]     phase_tdata;
  logic [NCH-1:0]       sincos_tvalid;
  logic [NCH*2*W-1:0]   sincos_tdata;
  logic                 mix_tvalid;
  logic [W-1:0]         mix_sin;
  logic [W-1:0]         mix_cos;
  logic                 running;

  int n_checks = 0;
  int n_err    = 0;

  tone_mix_gen #(.NCH(NCH), .W(W), .DECIM(5), .SETTLE(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .phase_inc     (phase_inc),
    .phase_tvalid  (phase_tvalid),
    .phase_tdata   (phase_tdata),
    .sincos_tvalid (sincos_tvalid),
    .sincos_tdata  (sincos_tdata),
    .mix_tvalid    (mix_tvalid),
    .mix_sin       (mix_sin),
    .mix_cos       (mix_cos),
    .running       (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s0, c0, s1, c1;
    int es_avg, ec_avg;
    int es_sat, ec_sat;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*2*W-1:0] pack(input int s0, input int c0, input int s1, input int c1);
    logic [W-1:0] a, b, c, d;
    a = W'(s0);
    b = W'(c0);
    c = W'(s1);
    d = W'(c1);
    return {c, d, a, b};
  endfunction

  // Steps until a mix pulse; channel 1 is held invalid for the first 'stall' edges
  task automatic run_to_pulse(input int stall, output int gap);
    gap = 0;
    do begin
      sincos_tvalid = (gap < stall) ? 2'b01 : 2'b11;
      step();
      gap++;
    end while (!mix_tvalid && gap < 30);
    sincos_tvalid = 2'b11;
  endtask

  initial begin
    int gap;
    int es, ec;

    tbl[0] = '{s0: 16384,  c0: 100,    s1: 8192,   c1: -300,  es_avg: 12288,  ec_avg: -100,  es_sat: 24576,  ec_sat: -200};
    tbl[1] = '{s0: -32768, c0: 32767,  s1: -32768, c1: 32767, es_avg: -32768, ec_avg: 32767, es_sat: -32768, ec_sat: 32767};
    tbl[2] = '{s0: 16384,  c0: -16384, s1: 24576,  c1: -24576,es_avg: 20480,  ec_avg: -20480,es_sat: 32767,  ec_sat: -32768};
    tbl[3] = '{s0: 1,      c0: 3,      s1: -2,     c1: 0,     es_avg: -1,     ec_avg: 1,     es_sat: -1,     ec_sat: 3};
    tbl[4] = '{s0: 7,      c0: -32768, s1: 8,      c1: 32767, es_avg: 7,      ec_avg: -1,    es_sat: 15,     ec_sat: -1};

    reset_n       = 1'b0;
    enable        = 1'b0;
    phase_inc     = '0;
    sincos_tvalid = '0;
    sincos_tdata  = '0;
    #3;
    chk("reset phase_tvalid", phase_tvalid, 0);
    chk("reset running", running, 0);
    chk("reset mix_tvalid", mix_tvalid, 0);
    chk("reset mix_sin", $signed(mix_sin), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("idle phase_tvalid", phase_tvalid, 0);
    chk("idle phase_tdata", phase_tdata, 0);

    // Phase sweep with no CORDIC valids: stays in PRIME, exercises both wraps
    phase_inc[15:0]  = 16'd3000;
    phase_inc[31:16] = 16'hF448;
    enable = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      step();
      if (n <= 8) begin
        es = 3000 * n;
      end else if (n == 9) begin
        es = -24472;
      end else begin
        es = -21472;
      end
      chk("phase ch0", $signed(phase_tdata[15:0]), es);
      chk("phase ch1", $signed(phase_tdata[31:16]), -es);
      chk("prime phase_tvalid", phase_tvalid, 1);
    end
    chk("prime without valid stays", running, 0);
    enable = 1'b0;
    step();
    chk("disable phases zero", phase_tdata, 0);
    chk("disable phase_tvalid", phase_tvalid, 0);

    // Settle then decimation timing with continuous valid
    enable        = 1'b1;
    sincos_tvalid = 2'b11;
    sincos_tdata  = pack(1000, 2000, 3000, 4000);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk("running timing", running, (n >= 5) ? 1 : 0);
      chk("pulse timing", mix_tvalid, (n == 10 || n == 15) ? 1 : 0);
    end
    chk("first mix_sin", $signed(mix_sin), 2000);

    for (int i = 0; i < 5; i++) begin
      sincos_tdata = pack(tbl[i].s0, tbl[i].c0, tbl[i].s1, tbl[i].c1);
      run_to_pulse(0, gap);
      chk("pulse gap", gap, 5);
`ifdef TONE_MIX_SAT_EN
      es = tbl[i].es_sat;
      ec = tbl[i].ec_sat;
`else
      es = tbl[i].es_avg;
      ec = tbl[i].ec_avg;
`endif
      chk("mix_sin vec", $signed(mix_sin), es);
      chk("mix_cos vec", $signed(mix_cos), ec);
    end

    run_to_pulse(3, gap);
    chk("stalled pulse gap", gap, 8);

    // Drop enable one edge before the due pulse; mix holds the last sample
    for (int n = 0; n < 4; n++) step();
    enable = 1'b0;
    step();
    chk("drop mix_tvalid", mix_tvalid, 0);
    chk("drop running", running, 0);
    chk("drop phase_tvalid", phase_tvalid, 0);
    chk("drop phases zero", phase_tdata, 0);
    chk("drop mix_sin held", $signed(mix_sin), es);

    // Partial prime, drop, re-enable: settle count must restart
    enable = 1'b1;
    step();
    step();
    step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("re-prime running", running, (n == 5) ? 1 : 0);
    end

    // Asynchronous reset in RUN
    run_to_pulse(0, gap);
    chk("run before reset", mix_tvalid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst running", running, 0);
    chk("async rst phase_tvalid", phase_tvalid, 0);
    chk("async rst mix_tvalid", mix_tvalid, 0);
    chk("async rst mix_sin", $signed(mix_sin), 0);
    chk("async rst phases", phase_tdata, 0);
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("post rst phase_tvalid", phase_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tone_mix_gen.md
# tone_mix_gen

- Synthesisable multi-tone stimulus generator for the CORDIC → FIR chain.
- Runs NCH phase accumulators with ±π wrap in 1.2.13 fixed point and drives phases to NCH external CORDIC sin/cos cores.
- Averages (or saturating-sums) the returned sin and cos samples, then emits one mixed sample every DECIM cycles at the FIR sampling rate.
- Replaces bench-only phase sweeps and fixed two-tone averaging with a parametrised, resettable, handshake-aware block.

## Interface

Parameters:
- `NCH`, 2: number of tones; power of two, 1..8.
- `W`, 16: sample and phase width; signed, phase in 1.2.13.
- `DECIM`, 5: CORDIC-rate to FIR-rate ratio; ≥1.
- `SETTLE`, 4: all-valid samples discarded after start (CORDIC warm-up).

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; high runs the sweep, low returns to IDLE.
- `phase_inc` in NCH*W: signed per-channel increment, channel k at [k*W +: W]; sampled every cycle; |inc| < π.
- `phase_tvalid` out 1: phases valid to CORDICs.
- `phase_tdata` out NCH*W: per-channel phase, same packing as `phase_inc`.
- `sincos_tvalid` in NCH: per-channel CORDIC result valid.
- `sincos_tdata` in NCH*2W: channel k = {sin, cos} at [k*2W +: 2W].
- `mix_tvalid` out 1: one-cycle pulse per mixed output.
- `mix_sin` out W: mixed sine sample.
- `mix_cos` out W: mixed cosine sample.
- `running` out 1: high in RUN.

## Operation

States:
- IDLE → PRIME: on `enable`=1.
- PRIME → RUN: after SETTLE all-valid cycles.
- Any state → IDLE: on `enable`=0.
- All-valid means &`sincos_tvalid`.

IDLE:
- Phases held at 0; `phase_tvalid`=0.
- Decimation and settle counters cleared.
- `mix_*` hold their last values.

PRIME and RUN:
- `phase_tvalid`=1.
- Each channel advances every cycle: s = phase + inc, computed in W+2 bits.
- If s ≥ PI_POS (0x6488): phase ← s − 2π, i.e. PI_NEG + (s − PI_POS).
- If s < PI_NEG (0x9B78): phase ← s + 2π.
- Otherwise: phase ← s.

PRIME:
- Counts all-valid cycles.
- The SETTLE-th one transitions to RUN; that sample is discarded.
- SETTLE=0: go straight to RUN on the first cycle.

RUN:
- The decimation counter 0..DECIM-1 advances only on all-valid cycles; otherwise it freezes.
- On an all-valid cycle with counter = DECIM-1:
  - `mix_sin` ← combine(sin_0..sin_{NCH-1}).
  - `mix_cos` ← combine(cos_0..cos_{NCH-1}).
  - `mix_tvalid`=1.
  - Counter wraps to 0.
- Combine:
  - Sign-extend each input to W+log2(NCH) bits and sum exactly.
  - Arithmetic right shift by log2(NCH).
  - Truncate to W. Cannot overflow.

Reset:
- `reset_n` low at any time forces IDLE immediately.
- All outputs 0, counters 0.
- `enable` is ignored until the first clk edge after release.

## Timing

- `phase_tdata`: registered. First cycle of PRIME shows 0; each following cycle shows the previous value advanced by `phase_inc`.
- Mixed output: 1-cycle latency from the accepting edge to `mix_*`/`mix_tvalid`.
- `mix_tvalid`:
  - High exactly one cycle per DECIM all-valid RUN cycles.
  - With continuous all-valid, the pulses are DECIM cycles apart.
  - Never high in IDLE or PRIME.
- Partial valid: channels with valid=0 stall the whole mix; no per-channel buffering.
- `enable` falling in RUN:
  - Next edge enters IDLE and zeroes the phases.
  - A pending sample is dropped; `mix_tvalid` is never asserted on that edge.
- `phase_inc` changes take effect on the next phase update, without glitching.

## Configuration

- `TONE_MIX_SAT_EN` defined:
  - Combine omits the shift.
  - The exact sum saturates to [−2^(W−1), 2^(W−1)−1]; unity gain per tone.
- Undefined: averaging combine as described under Operation.

## Test plan

1. Reset and defaults: assert `reset_n`=0 mid-RUN → all outputs 0 asynchronously; after release with `enable`=0, `phase_tvalid`=0.
2. Positive wrap: inc=3000, `enable`=1 → phase 0, 3000, …, 24000, then −24472. Check against the wrap rule: 27000 − 2π = −24472.
3. Negative wrap: inc=−3000 → phase 0, …, −24000, then 24472.
4. Averaging combine (NCH=2):
   - sin = 0x4000 and 0x2000 → `mix_sin`=12288.
   - sin = −32768 and −32768 → −32768.
   - With `TONE_MIX_SAT_EN`: sin = 16384 and 24576 → 32767.
5. Decimation and stall (DECIM=5, SETTLE=4):
   - Continuous valid → `running` rises after 4 valid cycles; `mix_tvalid` then pulses every 5 cycles.
   - `sincos_tvalid[1]`=0 for 3 cycles → the next pulse is 3 cycles late.
6. Enable drop: deassert `enable` one cycle before a due pulse → no `mix_tvalid`, IDLE next cycle, phases 0. Re-enable → PRIME restarts the settle count from 0.
